// File: rtl/icache_ifill_ctrl.sv
// icache_ifill_ctrl
// Refill and invalidation sequencer for the L1 instruction cache.
// It accepts one miss at a time and runs the IFILL request/ack/response
// handshake with the L2. The returned line and tag are written into the
// victim way. External line invalidations share the single array write port
// and always win it. A fill whose line is made stale by a kill, or by a
// same-index invalidation, still completes the L2 handshake. Its data is
// then discarded.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   miss_*                  miss request (valid/paddr/way/kill) and ready
//   ifill_req_*             IFILL request to L2 (valid/way/line-aligned paddr)
//   ifill_resp_*            L2 ack, full-line response valid and data
//                           (the beat field is ignored)
//   inv_valid_i/inv_paddr_i line invalidation request, index = paddr[11:5]
//   wr_*                    array write port (enable/way mask/idx/tag/valid/data)
//   fill_done_o             one-cycle pulse when a miss retires
module icache_ifill_ctrl #(
   parameter int N_WAY      = 4,
   parameter int PADDR_SIZE = 40,
   parameter int LINE_W     = 256,
   parameter int IDX_W      = 7,
   parameter int TAG_W      = 20
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     miss_valid_i,
   input  logic [PADDR_SIZE-1:0]    miss_paddr_i,
   input  logic [$clog2(N_WAY)-1:0] miss_way_i,
   input  logic                     miss_kill_i,
   output logic                     miss_ready_o,
   output logic                     ifill_req_valid_o,
   output logic [$clog2(N_WAY)-1:0] ifill_req_way_o,
   output logic [PADDR_SIZE-1:0]    ifill_req_paddr_o,
   input  logic                     ifill_resp_valid_i,
   input  logic                     ifill_resp_ack_i,
   input  logic [LINE_W-1:0]        ifill_resp_data_i,
   input  logic [1:0]               ifill_resp_beat_i,
   input  logic                     inv_valid_i,
   input  logic [11:0]              inv_paddr_i,
   output logic                     wr_en_o,
   output logic [N_WAY-1:0]         wr_way_mask_o,
   output logic [IDX_W-1:0]         wr_idx_o,
   output logic [TAG_W-1:0]         wr_tag_o,
   output logic                     wr_valid_o,
   output logic [LINE_W-1:0]        wr_data_o,
   output logic                     fill_done_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

   state_t                     state, state_nxt;
   logic [PADDR_SIZE-1:0]      paddr_q;
   logic [$clog2(N_WAY)-1:0]   way_q;
   logic [IDX_W-1:0]           idx_q;
   logic [TAG_W-1:0]           tag_q;
   logic [LINE_W-1:0]          line_q;
   logic                       drop_q;
   logic                       inv_vld_q;
   logic [IDX_W-1:0]           inv_idx_q;
   logic                       capture;
   logic                       unused_bits;

   // The beat field and the sub-line offset bits carry no information here.
   assign unused_bits = ^{ifill_resp_beat_i, miss_paddr_i[4:0], inv_paddr_i[4:0]};

   assign capture = ((state == REQ) && ifill_resp_ack_i && ifill_resp_valid_i) ||
                    ((state == WAIT) && ifill_resp_valid_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         paddr_q   <= '0;
         way_q     <= '0;
         idx_q     <= '0;
         tag_q     <= '0;
         line_q    <= '0;
         drop_q    <= 1'b0;
         inv_vld_q <= 1'b0;
         inv_idx_q <= '0;
      end else begin
         state     <= state_nxt;
         // The inv buffer drains every cycle because an inv always owns the
         // write port, so it is simply reloaded each cycle.
         inv_vld_q <= inv_valid_i;
         inv_idx_q <= inv_paddr_i[11:5];
         if (state == IDLE) begin
            if (miss_valid_i) begin
               paddr_q <= {miss_paddr_i[PADDR_SIZE-1:5], 5'b0};
               way_q   <= miss_way_i;
               idx_q   <= miss_paddr_i[11:5];
               tag_q   <= miss_paddr_i[TAG_W+11:12];
               drop_q  <= 1'b0;
            end
         end else if (miss_kill_i || (inv_valid_i && (inv_paddr_i[11:5] == idx_q))) begin
            drop_q <= 1'b1;
         end
         if (capture) line_q <= ifill_resp_data_i;
      end
   end

   always_comb begin
      state_nxt         = state;
      miss_ready_o      = 1'b0;
      ifill_req_valid_o = 1'b0;
      ifill_req_way_o   = '0;
      ifill_req_paddr_o = '0;
      wr_en_o           = 1'b0;
      wr_way_mask_o     = '0;
      wr_idx_o          = '0;
      wr_tag_o          = '0;
      wr_valid_o        = 1'b0;
      wr_data_o         = '0;
      fill_done_o       = 1'b0;

      if (inv_vld_q) begin
         wr_en_o       = 1'b1;
         wr_way_mask_o = '1;
         wr_idx_o      = inv_idx_q;
      end

      case (state)
         IDLE: begin
            miss_ready_o = 1'b1;
            if (miss_valid_i) state_nxt = REQ;
         end
         REQ: begin
            ifill_req_valid_o = 1'b1;
            ifill_req_way_o   = way_q;
            ifill_req_paddr_o = paddr_q;
            if (ifill_resp_ack_i) state_nxt = ifill_resp_valid_i ? WRITE : WAIT;
         end
         WAIT: begin
            if (ifill_resp_valid_i) state_nxt = WRITE;
         end
         WRITE: begin
            // A buffered inv holds the port; the fill waits in WRITE.
            if (!inv_vld_q) begin
               fill_done_o = 1'b1;
               state_nxt   = IDLE;
               if (!drop_q) begin
                  wr_en_o       = 1'b1;
                  wr_way_mask_o = N_WAY'(1) << way_q;
                  wr_idx_o      = idx_q;
                  wr_tag_o      = tag_q;
                  wr_valid_o    = 1'b1;
                  wr_data_o     = line_q;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache_ifill_ctrl.sv
// Randomized bench for icache_ifill_ctrl. The reference model tracks a miss
// as a transaction with a few progress flags (busy, acknowledged, line held,
// stale) plus the pending-invalidation slot. It predicts every output each
// cycle.
module tb_icache_ifill_ctrl;
   localparam int N_WAY = 4;
   localparam int PADDR_SIZE = 40;
   localparam int LINE_W = 256;
   localparam int IDX_W = 7;
   localparam int TAG_W = 20;
   localparam int N_CYC = 4000;

   logic                  clk;
   logic                  rst;
   logic                  miss_valid;
   logic [PADDR_SIZE-1:0] miss_paddr;
   logic [1:0]            miss_way;
   logic                  miss_kill;
   logic                  miss_ready;
   logic                  req_valid;
   logic [1:0]            req_way;
   logic [PADDR_SIZE-1:0] req_paddr;
   logic                  resp_valid;
   logic                  resp_ack;
   logic [LINE_W-1:0]     resp_data;
   logic [1:0]            resp_beat;
   logic                  inv_valid;
   logic [11:0]           inv_paddr;
   logic                  wr_en;
   logic [N_WAY-1:0]      wr_way_mask;
   logic [IDX_W-1:0]      wr_idx;
   logic [TAG_W-1:0]      wr_tag;
   logic                  wr_valid;
   logic [LINE_W-1:0]     wr_data;
   logic                  fill_done;

   int errors = 0;
   int checks = 0;
   int n_fill_writes = 0;

   // reference model
   bit                    busy, acked, have_line, stale, ipend;
   logic [IDX_W-1:0]      iidx, midx;
   logic [TAG_W-1:0]      mtag;
   logic [PADDR_SIZE-1:0] mpaddr;
   logic [1:0]            mway;
   logic [LINE_W-1:0]     mline;

   icache_ifill_ctrl #(
      .N_WAY(N_WAY), .PADDR_SIZE(PADDR_SIZE), .LINE_W(LINE_W),
      .IDX_W(IDX_W), .TAG_W(TAG_W)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .miss_valid_i(miss_valid), .miss_paddr_i(miss_paddr),
      .miss_way_i(miss_way), .miss_kill_i(miss_kill), .miss_ready_o(miss_ready),
      .ifill_req_valid_o(req_valid), .ifill_req_way_o(req_way),
      .ifill_req_paddr_o(req_paddr),
      .ifill_resp_valid_i(resp_valid), .ifill_resp_ack_i(resp_ack),
      .ifill_resp_data_i(resp_data), .ifill_resp_beat_i(resp_beat),
      .inv_valid_i(inv_valid), .inv_paddr_i(inv_paddr),
      .wr_en_o(wr_en), .wr_way_mask_o(wr_way_mask), .wr_idx_o(wr_idx),
      .wr_tag_o(wr_tag), .wr_valid_o(wr_valid), .wr_data_o(wr_data),
      .fill_done_o(fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      bit               fill_wr, done;
      logic             e_en, e_valid;
      logic [N_WAY-1:0] e_mask;
      logic [IDX_W-1:0] e_idx;
      logic [TAG_W-1:0] e_tag;
      logic [LINE_W-1:0] e_data;
      done    = busy && have_line && !ipend;
      fill_wr = done && !stale;
      e_en = 1'b0; e_valid = 1'b0; e_mask = '0; e_idx = '0; e_tag = '0; e_data = '0;
      if (ipend) begin
         e_en = 1'b1; e_mask = '1; e_idx = iidx;
      end else if (fill_wr) begin
         e_en = 1'b1; e_mask = N_WAY'(1 << mway); e_idx = midx;
         e_tag = mtag; e_valid = 1'b1; e_data = mline;
         n_fill_writes++;
      end
      check("miss_ready", LINE_W'(miss_ready), LINE_W'(!busy));
      check("req_valid",  LINE_W'(req_valid),  LINE_W'(busy && !acked));
      check("req_way",    LINE_W'(req_way),    LINE_W'((busy && !acked) ? mway : 2'd0));
      check("req_paddr",  LINE_W'(req_paddr),  LINE_W'((busy && !acked) ? mpaddr : '0));
      check("wr_en",      LINE_W'(wr_en),      LINE_W'(e_en));
      check("wr_mask",    LINE_W'(wr_way_mask), LINE_W'(e_mask));
      check("wr_idx",     LINE_W'(wr_idx),     LINE_W'(e_idx));
      check("wr_tag",     LINE_W'(wr_tag),     LINE_W'(e_tag));
      check("wr_valid",   LINE_W'(wr_valid),   LINE_W'(e_valid));
      check("wr_data",    wr_data,             e_data);
      check("fill_done",  LINE_W'(fill_done),  LINE_W'(done));
   endtask

   // Advance the model across the coming clock edge using the applied inputs.
   task automatic model_step();
      bit done;
      if (rst) begin
         busy = 0; acked = 0; have_line = 0; stale = 0; ipend = 0;
         return;
      end
      done = busy && have_line && !ipend;
      if (!busy) begin
         if (miss_valid) begin
            busy = 1; acked = 0; have_line = 0; stale = 0;
            mpaddr = {miss_paddr[PADDR_SIZE-1:5], 5'b0};
            mway   = miss_way;
            midx   = miss_paddr[11:5];
            mtag   = miss_paddr[31:12];
         end
      end else begin
         if (miss_kill || (inv_valid && inv_paddr[11:5] == midx)) stale = 1;
         if (!acked) begin
            if (resp_ack) begin
               acked = 1;
               if (resp_valid) begin have_line = 1; mline = resp_data; end
            end
         end else if (!have_line) begin
            if (resp_valid) begin have_line = 1; mline = resp_data; end
         end else if (done) begin
            busy = 0;
         end
      end
      ipend = inv_valid;
      iidx  = inv_paddr[11:5];
   endtask

   initial begin
      rst = 1'b1; miss_valid = 0; miss_paddr = '0; miss_way = '0; miss_kill = 0;
      resp_valid = 0; resp_ack = 0; resp_data = '0; resp_beat = '0;
      inv_valid = 0; inv_paddr = '0;
      busy = 0; acked = 0; have_line = 0; stale = 0; ipend = 0;
      iidx = '0; midx = '0; mtag = '0; mpaddr = '0; mway = '0; mline = '0;
      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         rst        = (cyc < 3) || ($urandom_range(0, 199) == 0);
         miss_valid = $urandom_range(0, 1) == 1;
         miss_paddr = {8'($urandom), $urandom};
         miss_way   = 2'($urandom);
         miss_kill  = $urandom_range(0, 19) == 0;
         resp_ack   = $urandom_range(0, 2) == 0;
         resp_valid = $urandom_range(0, 2) == 0;
         for (int w = 0; w < LINE_W / 32; w++) resp_data[w*32 +: 32] = $urandom;
         resp_beat  = 2'($urandom);
         inv_valid  = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 3) == 0) inv_paddr = {midx, 5'($urandom)};
         else inv_paddr = 12'($urandom);
         @(negedge clk);
         if (cyc > 0) compare_outputs();
         model_step();
      end
      check("fill_writes_seen", LINE_W'(n_fill_writes > 20), LINE_W'(1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_ifill_ctrl.md
# icache_ifill_ctrl

Refill and invalidation sequencer for the L1 instruction cache. It accepts one miss at a time from the icache control FSM and runs the IFILL request/ack/response handshake with the L2. It then writes the returned 256-bit line and tag into the chosen way. It also arbitrates the single array write port between line fills and external line invalidations, and drops fills that are made stale by a kill or by an invalidation that matches the line.

## Interface
- N_WAY, 4, number of ways
- PADDR_SIZE, 40, physical address width
- LINE_W, 256, cache line width in bits
- IDX_W, 7, set index width (128 sets)
- TAG_W, 20, tag width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- miss_valid_i  in  1  miss request from icache ctrl
- miss_paddr_i  in  PADDR_SIZE  physical address of missing line
- miss_way_i  in  $clog2(N_WAY)  victim way
- miss_kill_i  in  1  kill outstanding miss
- miss_ready_o  out  1  controller idle, miss may be accepted
- ifill_req_valid_o  out  1  IFILL request valid
- ifill_req_way_o  out  $clog2(N_WAY)  way field of IFILL request
- ifill_req_paddr_o  out  PADDR_SIZE  line-aligned address (bits [4:0] = 0)
- ifill_resp_valid_i  in  1  full line valid on data
- ifill_resp_ack_i  in  1  L2 accepted request
- ifill_resp_data_i  in  LINE_W  cache line
- ifill_resp_beat_i  in  2  ignored (line delivered in one cycle)
- inv_valid_i  in  1  invalidation request
- inv_paddr_i  in  12  invalidation address; index = bits [11:5]
- wr_en_o  out  1  array write strobe
- wr_way_mask_o  out  N_WAY  ways written
- wr_idx_o  out  IDX_W  set index
- wr_tag_o  out  TAG_W  tag written
- wr_valid_o  out  1  valid bit written (1 fill, 0 invalidate)
- wr_data_o  out  LINE_W  line data
- fill_done_o  out  1  one-cycle pulse, miss retired (written or dropped)

## Operation
- Address split: idx = paddr[11:5], tag = paddr[TAG_W+11:12].
- FSM states: IDLE, REQ, WAIT, WRITE. Reset value is IDLE.
- IDLE: miss_ready_o = 1. On miss_valid_i, latch paddr (line-aligned), way, idx and tag, clear the drop flag, and go to REQ. In IDLE, ifill_resp_* and miss_kill_i are ignored.
- REQ: ifill_req_valid_o = 1 with the latched way and paddr, held stable until ack.
  - ack without resp_valid: go to WAIT.
  - ack with resp_valid in the same cycle: capture data and go to WRITE.
- WAIT: on resp_valid, capture data into the line register and go to WRITE.
- WRITE:
  - If the inv buffer is valid, the inv write takes the port and the FSM stays in WRITE.
  - Otherwise, if the drop flag is clear: wr_en_o = 1, wr_way_mask_o = onehot(way), wr_valid_o = 1, latched tag/idx/data.
  - fill_done_o = 1 and the FSM goes to IDLE, whether the line was written or dropped.
- Drop flag is set by:
  - miss_kill_i in REQ, WAIT or WRITE;
  - an inv whose idx equals the latched idx, accepted in REQ, WAIT or WRITE.
- A dropped miss still completes the L2 handshake; the response is consumed and discarded.
- Invalidation path:
  - inv_valid_i is registered into a one-entry buffer (idx).
  - The following cycle it performs wr_en_o = 1, wr_way_mask_o = all ones, wr_valid_o = 0, wr_tag_o = 0, wr_data_o = 0.
  - Invalidation always has priority over the fill write, so the buffer drains every cycle and never overflows; back-to-back invs are processed one per cycle.
- Simultaneous inv arrival and fill WRITE: the fill writes this cycle and the inv writes next cycle, because the inv is only buffered in the arrival cycle.

## Timing
- Reset values: all outputs 0 except miss_ready_o = 1. FSM = IDLE, inv buffer empty, drop flag clear.
- Reset mid-operation returns to IDLE at once. No write or fill_done pulse is produced, and a late L2 response is ignored.
- Miss accept (cycle 0) → ifill_req_valid_o in cycle 1.
- Minimum miss latency: accept at cycle 0 → wr_en_o and fill_done_o at cycle 2 (ack+resp in cycle 1).
- Inv latency: inv_valid_i at cycle t → wr_en_o at t+1.
- miss_ready_o is 0 from the cycle after accept through the fill_done_o cycle. It is 1 again the cycle after fill_done_o.
- Outputs are registered or decoded from state only. There is no combinational path from ifill_resp_* to wr_*.

## Test plan
- Basic fill: miss paddr 0x80001240, way 2; ack at cycle 2, resp at cycle 4 with data 0xA5..A5 → wr_en_o once, mask 4'b0100, idx 0x12, tag 0x80001, wr_valid_o = 1, fill_done_o in the same cycle.
- Same-cycle ack+resp: ack and resp in cycle 1 → write in cycle 2; ifill_req_valid_o high exactly 1 cycle.
- Kill during WAIT: miss_kill_i in WAIT, resp later → no wr_en_o, fill_done_o = 1, miss_ready_o = 1 the next cycle.
- Matching inv: inv paddr 0x240 during WAIT of a miss to 0x80001240 → inv write (mask 4'b1111, wr_valid_o = 0, idx 0x12); fill dropped, no fill write.
- Inv collision: inv arrives in the WRITE cycle → fill writes first. With an inv already buffered, the fill stalls 1 cycle; with 3 back-to-back invs, the fill stalls 3 cycles and then writes.
- Reset in WAIT: rst_i high one cycle, then resp_valid → no write, no fill_done_o, all outputs 0, miss_ready_o = 1.
